baud_tick_ctrl: RTL and testbench

BAUD_TICK_CTRL -- requirements
Module: baud_tick_ctrl

---
 rtl/baud_tick_ctrl_if.sv | 41 ++++
 rtl/baud_tick_ctrl.sv | 164 ++++++++++++++++
 tb/tb_baud_tick_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_ctrl_if.sv
// ============================================================================
// Module      : baud_tick_ctrl_if
// Description : Control and status bundle for the baud tick controller.
//               master = the agent driving enable and divisor requests,
//               slave  = baud_tick_ctrl itself.
// Signals     : en       (m->s) 1 = generate ticks
//               div_req  (m->s) divisor-change request, held until div_ack
//               div_val  (m->s) requested divisor, DIV_W bits
//               div_ack  (s->m) one-cycle acknowledge, divisor applied
//               rx_tick  (s->m) oversample tick
//               tx_tick  (s->m) bit tick, every OVS-th rx_tick
//               busy     (s->m) divisor change pending
//               cur_div  (s->m) divisor in use, DIV_W bits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface baud_tick_ctrl_if #(
  parameter int DIV_W = 10
);
  logic             en;
  logic             div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             rx_tick;
  logic             tx_tick;
  logic             busy;
  logic [DIV_W-1:0] cur_div;

  modport master (
    output en, div_req, div_val,
    input  div_ack, rx_tick, tx_tick, busy, cur_div
  );

  modport slave (
    input  en, div_req, div_val,
    output div_ack, rx_tick, tx_tick, busy, cur_div
  );
endinterface

`default_nettype wire

// File: rtl/baud_tick_ctrl.sv
// ============================================================================
// Module      : baud_tick_ctrl
// Description : Programmable baud tick generator. Divides fast_clock by
//               cur_div to form rx_tick and divides rx_tick by OVS to form
//               tx_tick. Divisor changes requested while running are held
//               pending and applied on a tx bit boundary so no bit period is
//               ever distorted.
// Ports       : fast_clock  in   sole clock, rising edge
//               rst         in   asynchronous reset, active low
//               resync      in   counter restart pulse (only with
//                                BAUD_TICK_RESYNC_EN defined)
//               bus         slave modport of baud_tick_ctrl_if
// Options     : `define BAUD_TICK_RESYNC_EN adds the resync input and logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_ctrl #(
  parameter int DIV_W   = 10,
  parameter int OVS     = 16,
  parameter int DEF_DIV = 325
) (
  input  wire logic       fast_clock,
  input  wire logic       rst,
`ifdef BAUD_TICK_RESYNC_EN
  input  wire logic       resync,
`endif
  baud_tick_ctrl_if.slave bus
);

  localparam int               c_OVS_W    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [DIV_W-1:0] c_DEF_DIV  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_DIV_TWO  = DIV_W'(2);
  localparam logic [c_OVS_W-1:0] c_OVS_LAST = c_OVS_W'(OVS - 1);
  localparam logic [c_OVS_W-1:0] c_OVS_ONE  = c_OVS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_cur_div;
  logic [DIV_W-1:0]   r_pend_div;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [c_OVS_W-1:0] r_ovs_cnt;
  logic               r_rx_tick;
  logic               r_tx_tick;
  logic               r_div_ack;
  logic               r_busy;

  logic               w_req;
  logic               w_resync;
  logic               w_div_last;
  logic               w_ovs_last;
  logic [DIV_W-1:0]   w_div_clamp;

  // A request still held during its own acknowledge cycle is not a new one.
  assign w_req       = bus.div_req & ~r_div_ack;
  // Divisors below 2 would collapse the counter; force the minimum of 2.
  assign w_div_clamp = (bus.div_val < c_DIV_TWO) ? c_DIV_TWO : bus.div_val;
  assign w_div_last  = (r_div_cnt == (r_cur_div - c_DIV_ONE));
  assign w_ovs_last  = (r_ovs_cnt == c_OVS_LAST);

`ifdef BAUD_TICK_RESYNC_EN
  assign w_resync = resync;
`else
  assign w_resync = 1'b0;
`endif

  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cur_div  <= c_DEF_DIV;
      r_pend_div <= c_DEF_DIV;
      r_div_cnt  <= '0;
      r_ovs_cnt  <= '0;
      r_rx_tick  <= 1'b0;
      r_tx_tick  <= 1'b0;
      r_div_ack  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
      r_div_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          r_ovs_cnt <= '0;
          r_busy    <= 1'b0;
          // Loading here and entering RUN on the same edge lets a combined
          // en+div_req start the very first bit at the new divisor.
          if (w_req) begin
            r_cur_div <= w_div_clamp;
            r_div_ack <= 1'b1;
          end
          if (bus.en) begin
            r_state <= S_RUN;
          end
        end

        S_RUN, S_PEND: begin
          if (!bus.en) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_ovs_cnt <= '0;
            r_busy    <= 1'b0;
            // Stopping ends the bit anyway, so a pending divisor is safe to
            // apply right away.
            if (r_state == S_PEND) begin
              r_cur_div <= r_pend_div;
              r_div_ack <= 1'b1;
            end
          end else begin
            if (w_resync) begin
              r_div_cnt <= '0;
              r_ovs_cnt <= '0;
            end else if (w_div_last) begin
              r_div_cnt <= '0;
              r_rx_tick <= 1'b1;
              if (w_ovs_last) begin
                r_ovs_cnt <= '0;
                r_tx_tick <= 1'b1;
                // Bit boundary: counters are already restarting, so swapping
                // the divisor here leaves every bit period intact.
                if (r_state == S_PEND) begin
                  r_cur_div <= r_pend_div;
                  r_div_ack <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_RUN;
                end
              end else begin
                r_ovs_cnt <= r_ovs_cnt + c_OVS_ONE;
              end
            end else begin
              r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end

            if ((r_state == S_RUN) && w_req) begin
              r_pend_div <= w_div_clamp;
              r_busy     <= 1'b1;
              r_state    <= S_PEND;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_tick = r_rx_tick;
  assign bus.tx_tick = r_tx_tick;
  assign bus.div_ack = r_div_ack;
  assign bus.busy    = r_busy;
  assign bus.cur_div = r_cur_div;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_ctrl.sv
// ============================================================================
// Module      : tb_baud_tick_ctrl
// Description : Scoreboard bench for baud_tick_ctrl. Stimulus tasks compute
//               the cycle of every expected rx_tick / tx_tick / div_ack from
//               the divisor arithmetic and queue them; an independent monitor
//               compares DUT output events against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_tick_ctrl;

  localparam int DIV_W   = 10;
  localparam int OVS     = 16;
  localparam int DEF_DIV = 325;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_div = DEF_DIV;

  typedef struct {
    int t;
    bit rx;
    bit tx;
    bit ack;
    int d;
  } ev_t;

  ev_t exp_q[$];

  baud_tick_ctrl_if #(.DIV_W(DIV_W)) bus ();

`ifdef BAUD_TICK_RESYNC_EN
  logic resync = 1'b0;
`endif

  baud_tick_ctrl #(
    .DIV_W   (DIV_W),
    .OVS     (OVS),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .fast_clock (clk),
    .rst        (rst),
`ifdef BAUD_TICK_RESYNC_EN
    .resync     (resync),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_event: expected rx=%0b tx=%0b ack=%0b at cycle %0d, nothing seen",
               exp_q[0].rx, exp_q[0].tx, exp_q[0].ack, exp_q[0].t);
      void'(exp_q.pop_front());
    end
    if (bus.rx_tick || bus.tx_tick || bus.div_ack) begin
      n_chk++;
      if (exp_q.size() == 0 || exp_q[0].t != cyc) begin
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d got rx=%0b tx=%0b ack=%0b, required no event",
                 cyc, bus.rx_tick, bus.tx_tick, bus.div_ack);
      end else begin
        e = exp_q.pop_front();
        if (bus.rx_tick !== e.rx || bus.tx_tick !== e.tx || bus.div_ack !== e.ack ||
            int'(bus.cur_div) != e.d) begin
          n_fail++;
          $display("FAIL event@%0d: got rx=%0b tx=%0b ack=%0b div=%0d, required rx=%0b tx=%0b ack=%0b div=%0d",
                   cyc, bus.rx_tick, bus.tx_tick, bus.div_ack, bus.cur_div,
                   e.rx, e.tx, e.ack, e.d);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_event: cycle %0d got no event, required rx=%0b tx=%0b ack=%0b",
               cyc, exp_q[0].rx, exp_q[0].tx, exp_q[0].ack);
      void'(exp_q.pop_front());
    end
  end

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int t, input bit rx, input bit tx, input bit ack, input int d);
    ev_t e;
    e.t = t; e.rx = rx; e.tx = tx; e.ack = ack; e.d = d;
    exp_q.push_back(e);
  endtask

  // Ticks m_lo..m_hi of a bit stream whose counters were zero in cycle s.
  task automatic push_ticks(input int s, input int d, input int m_lo, input int m_hi);
    for (int m = m_lo; m <= m_hi; m++)
      push_ev(s + m * d, 1'b1, (m % OVS) == 0, 1'b0, d);
  endtask

  task automatic idle_div(input int v);
    int c;
    c = cyc;
    bus.div_req = 1'b1;
    bus.div_val = DIV_W'(v);
    m_div = clampd(v);
    push_ev(c + 1, 1'b0, 1'b0, 1'b1, m_div);
    step();
    chk("idle_cur_div", int'(bus.cur_div), m_div);
    step();
    bus.div_req = 1'b0;
    step(2);
  endtask

  // Start from IDLE (optionally loading a divisor on the same edge), run n
  // rx ticks, then drop en somewhere inside the following tick period.
  task automatic run_and_stop(input bit with_req, input int v, input int n);
    int s, r;
    s = cyc + 1;
    bus.en = 1'b1;
    if (with_req) begin
      bus.div_req = 1'b1;
      bus.div_val = DIV_W'(v);
      m_div = clampd(v);
      push_ev(s, 1'b0, 1'b0, 1'b1, m_div);
    end
    push_ticks(s, m_div, 1, n);
    step();
    if (with_req) chk("load_run_div", int'(bus.cur_div), m_div);
    step();
    bus.div_req = 1'b0;
    r = int'($urandom_range(m_div - 1, 0));
    wait_until(s + n * m_div + r);
    bus.en = 1'b0;
    step(2);
    chk("stop_busy", int'(bus.busy), 0);
  endtask

  // Change divisor while running; it must take effect on the next bit edge.
  task automatic change_in_run(input int v, input int kmin, input int kmax, input int n2);
    int s, rq, nb, ta, d1, d2, r;
    d1 = m_div;
    d2 = clampd(v);
    s  = cyc + 1;
    bus.en = 1'b1;
    rq = s + int'($urandom_range(kmax, kmin));
    nb = ((rq + 2 - s) + OVS * d1 - 1) / (OVS * d1);
    ta = s + nb * OVS * d1;
    push_ticks(s, d1, 1, nb * OVS - 1);
    push_ev(ta, 1'b1, 1'b1, 1'b1, d2);
    push_ticks(ta, d2, 1, n2);
    wait_until(rq);
    bus.div_req = 1'b1;
    bus.div_val = DIV_W'(v);
    step();
    chk("pend_busy_start", int'(bus.busy), 1);
    wait_until(ta - 1);
    chk("pend_busy_end", int'(bus.busy), 1);
    chk("pend_old_div", int'(bus.cur_div), d1);
    step();
    chk("apply_busy", int'(bus.busy), 0);
    step();
    bus.div_req = 1'b0;
    m_div = d2;
    r = int'($urandom_range(d2 - 1, 0));
    wait_until(ta + n2 * d2 + r);
    bus.en = 1'b0;
    step(2);
  endtask

  // Request while running, then stop (or reset) before the bit edge.
  task automatic pend_then_stop(input int v, input bit use_rst);
    int s, rq, x, d;
    d  = m_div;
    s  = cyc + 1;
    bus.en = 1'b1;
    rq = s + OVS * d + 1;
    x  = rq + 1 + int'($urandom_range(4 * d, 0));
    push_ticks(s, d, 1, (x - s) / d);
    if (!use_rst) push_ev(x + 1, 1'b0, 1'b0, 1'b1, clampd(v));
    wait_until(rq);
    bus.div_req = 1'b1;
    bus.div_val = DIV_W'(v);
    wait_until(x);
    chk("pend_busy", int'(bus.busy), 1);
    if (use_rst) begin
      rst = 1'b0;
      bus.en = 1'b0;
      bus.div_req = 1'b0;
      #1;
      chk("rst_pend_div", int'(bus.cur_div), DEF_DIV);
      chk("rst_pend_busy", int'(bus.busy), 0);
      step(4);
      rst = 1'b1;
      step(4);
      chk("post_rst_div", int'(bus.cur_div), DEF_DIV);
      m_div = DEF_DIV;
    end else begin
      bus.en = 1'b0;
      step();
      chk("stop_apply_div", int'(bus.cur_div), clampd(v));
      chk("stop_apply_busy", int'(bus.busy), 0);
      step();
      bus.div_req = 1'b0;
      m_div = clampd(v);
      step(3);
    end
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = '0;
    rst         = 1'b0;
    step(20);
    chk("rst_cur_div", int'(bus.cur_div), DEF_DIV);
    chk("rst_busy",    int'(bus.busy),    0);
    chk("rst_ack",     int'(bus.div_ack), 0);
    chk("rst_rx",      int'(bus.rx_tick), 0);
    chk("rst_tx",      int'(bus.tx_tick), 0);

    rst = 1'b1;
    run_and_stop(1'b0, 0, 17);          // default divisor, tx at 5200 cycles
    idle_div(4);
    run_and_stop(1'b0, 0, 20);          // rx every 4, tx every 64
    change_in_run(8, 12, 80, 20);       // 4 -> 8 at the next bit edge
    idle_div(0);                        // clamps to 2
    run_and_stop(1'b0, 0, 18);
    pend_then_stop(7, 1'b1);            // reset discards pending divisor
    idle_div(3);
    pend_then_stop(1, 1'b0);            // stop applies pending divisor now

    for (int it = 0; it < 8; it++) begin
      int v, mode, n;
      v    = int'($urandom_range(9, 0));
      mode = int'($urandom_range(3, 0));
      n    = int'($urandom_range(24, 5));
      case (mode)
        0: begin idle_div(v); run_and_stop(1'b0, 0, n); end
        1: run_and_stop(1'b1, v, n);
        2: change_in_run(v, 0, 40 * m_div, n);
        default: pend_then_stop(v, 1'b0);
      endcase
    end

    step(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
